// File: rtl/event_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : event_wr_arbiter
//  Description : Round-robin arbiter sharing the single write port of the
//                event FIFO among N_SRC event sources. Each source owns a
//                one-entry holding slot. Occupied slots are drained into the
//                FIFO at one event per cycle. Events that hit a slot which is
//                still occupied are dropped and counted per source in a
//                saturating counter.
//
//  Ports       : aclk        - clock, rising edge
//                areset      - synchronous active-high reset
//                src_valid   - per-source one-cycle event strobe
//                src_data    - per-source payload, source i at [i*DATA_W +: DATA_W]
//                src_en      - per-source accept enable
//                fifo_full   - FIFO full flag (used combinationally)
//                fifo_wr_en  - FIFO write strobe
//                fifo_data   - FIFO write data (0 when nothing is granted)
//                fifo_src    - index of the granted source (0 when idle)
//                pending     - slot-occupied flags
//                clr_drops   - pulse that clears all drop counters
//                drop_cnt    - saturating drop counters, source i at [i*CNT_W +: CNT_W]
//
//  Revision    : 1.0 - initial release
// ============================================================================
module event_wr_arbiter #(
    parameter int N_SRC  = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                                         aclk,
    input  logic                                         areset,
    input  logic [N_SRC-1:0]                             src_valid,
    input  logic [N_SRC*DATA_W-1:0]                      src_data,
    input  logic [N_SRC-1:0]                             src_en,
    input  logic                                         fifo_full,
    output logic                                         fifo_wr_en,
    output logic [DATA_W-1:0]                            fifo_data,
    output logic [((N_SRC > 1) ? $clog2(N_SRC) : 1)-1:0] fifo_src,
    output logic [N_SRC-1:0]                             pending,
    input  logic                                         clr_drops,
    output logic [N_SRC*CNT_W-1:0]                       drop_cnt
);

    localparam int C_PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    // One extra bit so rr_ptr + offset can be reduced modulo N_SRC even
    // when N_SRC is not a power of two.
    localparam logic [C_PTR_W:0] C_N_SRC = (C_PTR_W+1)'(N_SRC);
    localparam logic [C_PTR_W-1:0] C_LAST = C_PTR_W'(N_SRC - 1);

    logic [C_PTR_W-1:0] r_rr_ptr;

    logic [N_SRC-1:0]   w_occ;
    logic [DATA_W-1:0]  w_slot_data [N_SRC];
    logic               w_gnt_valid;
    logic [C_PTR_W-1:0] w_gnt_idx;
    logic [C_PTR_W:0]   w_scan;
    logic               w_wr;
    logic [C_PTR_W-1:0] w_ptr_nxt;

    // ------------------------------------------------------------------
    // Grant: first occupied slot searching upward from rr_ptr with wrap.
    // Grant is suppressed during reset so nothing is written while the
    // slots are being discarded.
    // ------------------------------------------------------------------
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        w_scan      = '0;
        for (int k = 0; k < N_SRC; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (C_PTR_W+1)'(k);
            if (w_scan >= C_N_SRC) begin
                w_scan = w_scan - C_N_SRC;
            end
            if (!w_gnt_valid && !areset && w_occ[w_scan[C_PTR_W-1:0]]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = w_scan[C_PTR_W-1:0];
            end
        end
    end

    assign w_wr       = w_gnt_valid & ~fifo_full;
    assign w_ptr_nxt  = (w_gnt_idx == C_LAST) ? '0 : w_gnt_idx + C_PTR_W'(1);

    assign fifo_wr_en = w_wr;
    assign fifo_data  = w_gnt_valid ? w_slot_data[w_gnt_idx] : '0;
    assign fifo_src   = w_gnt_valid ? w_gnt_idx : '0;
    assign pending    = w_occ;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rr_ptr <= '0;
        end else if (w_wr) begin
            r_rr_ptr <= w_ptr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Per-source holding slot and drop counter
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        logic              r_occ;
        logic [DATA_W-1:0] r_data;
        logic [CNT_W-1:0]  r_drop;
        logic              w_accept;
        logic              w_written;

        assign w_accept  = src_valid[i] & src_en[i];
        assign w_written = w_wr & (w_gnt_idx == C_PTR_W'(i));

        always_ff @(posedge aclk) begin
            if (areset) begin
                r_occ  <= 1'b0;
                r_data <= '0;
                r_drop <= '0;
            end else begin
                // A slot being written this cycle can take a new event in
                // the same cycle; only a slot that stays full drops it.
                if (w_accept && (!r_occ || w_written)) begin
                    r_occ  <= 1'b1;
                    r_data <= src_data[i*DATA_W +: DATA_W];
                end else if (w_written) begin
                    r_occ  <= 1'b0;
                end

                if (clr_drops) begin
                    r_drop <= '0;
                end else if (w_accept && r_occ && !w_written && (r_drop != '1)) begin
                    r_drop <= r_drop + CNT_W'(1);
                end
            end
        end

        assign w_occ[i]                      = r_occ;
        assign w_slot_data[i]                = r_data;
        assign drop_cnt[i*CNT_W +: CNT_W]    = r_drop;
    end

endmodule
`default_nettype wire

// File: tb/tb_event_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_event_wr_arbiter
//  Description : Self-checking bench for event_wr_arbiter. Expected FIFO
//                writes are queued as stimulus is issued; a monitor pops and
//                compares on every fifo_wr_en. Status outputs are checked
//                directly against hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_event_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 16;

    logic            aclk = 1'b0;
    logic            areset;
    logic [N-1:0]    src_valid;
    logic [N*DW-1:0] src_data;
    logic [N-1:0]    src_en;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_data;
    logic [1:0]      fifo_src;
    logic [N-1:0]    pending;
    logic            clr_drops;
    logic [N*CW-1:0] drop_cnt;

    int tests = 0;
    int fails = 0;

    logic [DW+1:0] exp_q [$];
    logic [DW+1:0] mon_exp;

    event_wr_arbiter #(.N_SRC(N), .DATA_W(DW), .CNT_W(CW)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_en     (src_en),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .fifo_src   (fifo_src),
        .pending    (pending),
        .clr_drops  (clr_drops),
        .drop_cnt   (drop_cnt)
    );

    always #5 aclk = ~aclk;

    // Monitor: every write must match the head of the expected queue.
    always @(negedge aclk) begin
        if (fifo_wr_en === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got data=%h src=%0d, required no write",
                         fifo_data, fifo_src);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({fifo_data, fifo_src} !== mon_exp) begin
                    fails++;
                    $display("FAIL write_data: got data=%h src=%0d, required data=%h src=%0d",
                             fifo_data, fifo_src, mon_exp[DW+1:2], mon_exp[1:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d, input logic [1:0] s);
        exp_q.push_back({d, s});
    endtask

    task automatic strobe(input int src, input logic [DW-1:0] d);
        src_valid[src]          = 1'b1;
        src_data[src*DW +: DW]  = d;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        tick();
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
    endtask

    initial begin
        areset    = 1'b1;
        src_valid = '0;
        src_data  = '0;
        src_en    = '1;
        fifo_full = 1'b0;
        clr_drops = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_pending",  64'(pending),    64'd0);
        check("rst_wr_en",    64'(fifo_wr_en), 64'd0);
        check("rst_data",     64'(fifo_data),  64'd0);
        check("rst_src",      64'(fifo_src),   64'd0);
        check("rst_drop_cnt", drop_cnt,        64'd0);
        areset = 1'b0;
        tick();

        // Single event from source 2
        strobe(2, 8'h5A);
        push(8'h5A, 2'd2);
        tick();
        src_valid = '0;
        check("single_pending_set", 64'(pending), 64'h4);
        drain("single_drain");
        check("single_pending_clr", 64'(pending), 64'd0);

        // Fresh reset so rr_ptr starts at 0 for the round-robin sequence
        do_reset();
        tick();
        strobe(0, 8'h11); strobe(1, 8'h22); strobe(2, 8'h33); strobe(3, 8'h44);
        push(8'h11, 2'd0); push(8'h22, 2'd1); push(8'h33, 2'd2); push(8'h44, 2'd3);
        tick();
        src_valid = '0;
        drain("rr_round1");
        strobe(1, 8'h55); strobe(3, 8'h66);
        push(8'h55, 2'd1); push(8'h66, 2'd3);
        tick();
        src_valid = '0;
        drain("rr_round2");

        // Drop while FIFO full; slot keeps the first event
        fifo_full = 1'b1;
        strobe(0, 8'h01);
        tick();
        src_valid = '0;
        tick();
        strobe(0, 8'h02);
        tick();
        src_valid = '0;
        check("full_drop_cnt0", 64'(drop_cnt[0 +: CW]), 64'd1);
        check("full_pending",   64'(pending),           64'h1);
        check("full_held_data", 64'(fifo_data),         64'h01);
        check("full_no_write",  64'(fifo_wr_en),        64'd0);
        push(8'h01, 2'd0);
        fifo_full = 1'b0;
        drain("full_release");

        // Back-to-back strobes from source 1: same-cycle reload, no drops
        for (int i = 0; i < 10; i++) begin
            strobe(1, 8'(8'h80 + i));
            push(8'(8'h80 + i), 2'd1);
            tick();
        end
        src_valid = '0;
        drain("b2b_drain");
        check("b2b_drop_cnt1", 64'(drop_cnt[CW +: CW]), 64'd0);

        // Saturation of drop counter 3
        fifo_full = 1'b1;
        strobe(3, 8'h3C);
        repeat (70000) tick();
        check("sat_drop_cnt3", 64'(drop_cnt[3*CW +: CW]), 64'hFFFF);
        clr_drops = 1'b1;
        tick();
        clr_drops = 1'b0;
        src_valid = '0;
        check("clr_drop_cnt", drop_cnt, 64'd0);
        push(8'h3C, 2'd3);
        fifo_full = 1'b0;
        drain("sat_release");

        // src_en low: ignored, not counted
        src_en = 4'b1110;
        strobe(0, 8'h77);
        tick();
        src_valid = '0;
        src_en    = '1;
        tick();
        check("en_off_pending",  64'(pending),  64'd0);
        check("en_off_drop_cnt", drop_cnt,      64'd0);

        // Move rr_ptr to 2, then reset with sources 1 and 2 pending
        strobe(1, 8'h91);
        push(8'h91, 2'd1);
        tick();
        src_valid = '0;
        drain("pre_reset_write");
        fifo_full = 1'b1;
        strobe(1, 8'hA1); strobe(2, 8'hA2);
        tick();
        src_valid = '0;
        check("pre_reset_pending", 64'(pending), 64'h6);
        areset    = 1'b1;
        fifo_full = 1'b0;
        #1;
        check("reset_no_write", 64'(fifo_wr_en), 64'd0);
        tick();
        check("reset_pending", 64'(pending), 64'd0);
        areset = 1'b0;
        repeat (5) tick();
        // rr_ptr back at 0: source 0 wins over source 3
        strobe(0, 8'hB0); strobe(3, 8'hB3);
        push(8'hB0, 2'd0); push(8'hB3, 2'd3);
        tick();
        src_valid = '0;
        drain("post_reset_order");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/event_wr_arbiter.md
# event_wr_arbiter

Round-robin arbiter that shares the single write port of the event FIFO among several event sources. Each source gets a one-entry holding slot. The arbiter drains occupied slots into the FIFO at one event per cycle, and stalls while the FIFO reports full. Events that arrive at an occupied slot are dropped and counted per source, so software can read losses alongside the FIFO status.

## Interface
Parameters:
- N_SRC, 4, number of event sources (2..8)
- DATA_W, 8, event width; matches the FIFO `data_in` width
- CNT_W, 16, width of each per-source drop counter

Ports:
- aclk  in  1  clock; everything is synchronous to the rising edge
- areset  in  1  synchronous, active-high reset
- src_valid  in  N_SRC  one-cycle event strobe per source
- src_data  in  N_SRC*DATA_W  event payload; source i occupies bits [i*DATA_W +: DATA_W]
- src_en  in  N_SRC  per-source accept enable
- fifo_full  in  1  full flag from the event FIFO
- fifo_wr_en  out  1  write strobe to the FIFO (`wr_en`)
- fifo_data  out  DATA_W  write data to the FIFO (`data_in`)
- fifo_src  out  $clog2(N_SRC)  index of the source being written (for debug/ILA)
- pending  out  N_SRC  slot-occupied flags
- clr_drops  in  1  one-cycle pulse; clears all drop counters
- drop_cnt  out  N_SRC*CNT_W  saturating drop counters; source i occupies bits [i*CNT_W +: CNT_W]

## Operation
- State:
  - per-source slot: occupied bit plus DATA_W data register
  - rr_ptr: $clog2(N_SRC) bits
  - per-source drop counters
- Grant:
  - Combinational from registered state.
  - Select the first occupied slot, searching from rr_ptr upward with wrap-around modulo N_SRC.
- Write:
  - fifo_wr_en = |pending & ~fifo_full.
  - fifo_data and fifo_src come from the granted slot; both are 0 when no slot is granted.
- On a write:
  - The granted slot clears.
  - rr_ptr ← (grant+1) mod N_SRC.
- rr_ptr holds when no write occurs.
- Per-source slot update each cycle, with accept = src_valid[i] & src_en[i]:
  - accept, slot empty → load data, set occupied.
  - accept, slot granted and written this cycle → load the new data and stay occupied. This is not a drop.
  - accept, slot occupied and not written this cycle (lost arbitration, or fifo_full) → keep the old data; drop_cnt[i] += 1, saturating at 2^CNT_W−1.
  - src_valid with src_en low → ignored; not counted.
  - Deasserting src_en does not flush the slot; an already-pending event is still drained.
- clr_drops:
  - All counters ← 0.
  - clr_drops has priority over a same-cycle increment, so the counter reads 0 afterwards.
- fifo_full high: no write, rr_ptr holds, and all pending slots hold their data.
- Mid-operation reset: pending events are discarded and counters cleared. No write is issued while areset is high.

## Timing
- Reset values:
  - pending = 0
  - rr_ptr = 0
  - drop_cnt = 0
  - fifo_wr_en = 0, fifo_data = 0, fifo_src = 0
- Latency: src_valid sampled at edge k → pending set after edge k → fifo_wr_en high in the following cycle, provided fifo_full is low and the source wins arbitration. The FIFO captures the event at edge k+1.
- Throughput: one FIFO write per cycle.
- Fairness: with all slots continuously occupied and the FIFO never full, each source is written once every N_SRC cycles.
- fifo_full is used combinationally in the same cycle. The FIFO must deassert full in the cycle a slot becomes free.
- drop_cnt and pending are registered outputs.

## Test plan
- Reset, then src_valid[2]=1 with data 0x5A for one cycle, fifo_full=0 → fifo_wr_en high for exactly one cycle, one cycle after the strobe, with fifo_data=0x5A and fifo_src=2; pending returns to 0.
- All four sources strobe simultaneously with data 0x11/0x22/0x33/0x44 → writes on four consecutive cycles in order 0x11, 0x22, 0x33, 0x44. Then a second simultaneous strobe from sources 1 and 3 → order is source 1 then source 3, because rr_ptr=0 after the first round.
- fifo_full=1; source 0 strobes 0x01, then 0x02 two cycles later → drop_cnt[0]=1 and the slot holds 0x01. Release fifo_full → exactly one write, of 0x01.
- Source 1 holds src_valid high for 10 cycles with incrementing data, no contention → 10 writes, drop_cnt[1]=0; each write is reloaded in the same cycle.
- Hold fifo_full=1 and strobe source 3 for 70000 cycles (CNT_W=16) → drop_cnt[3]=0xFFFF, saturated. Pulse clr_drops in a cycle that also has a drop → drop_cnt[3]=0.
- src_en[0]=0 with source 0 strobing → no write, no drop count. Then assert areset while sources 1 and 2 are pending → pending=0, no writes after reset, rr_ptr back to 0.
